// File: rtl/regfile_rat_pkg.sv
// rtl/regfile_rat_pkg.sv - shared widths, commit bus struct and local types for the register file / RAT
package rv_structs;
    localparam int NUM_REGS  = 32;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
endpackage

package rob_entry_structs;
    import rv_structs::*;

    localparam int ROB_IDX_W = 5;

    // One retiring result from the ROB headed for the architectural file
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      value;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [REG_IDX_W-1:0] regfile_idx;
    } rob_to_regfile;
endpackage

package regfile_rat_pkg;
    import rv_structs::*;
    import rob_entry_structs::*;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
endpackage

// File: rtl/regfile_rat_if.sv
// rtl/regfile_rat_if.sv - issue, commit, flush and operand-read bundle for regfile_rat
interface regfile_rat_if;
    import rob_entry_structs::*;
    import regfile_rat_pkg::*;

    logic          issue;
    reg_idx_t      issue_rd;
    rob_idx_t      issue_rob_idx;
    rob_to_regfile rob_regfile_bus;
    logic          flush;
    reg_idx_t      rs1_idx;
    reg_idx_t      rs2_idx;
    xlen_t         rs1_value;
    logic          rs1_busy;
    rob_idx_t      rs1_tag;
    xlen_t         rs2_value;
    logic          rs2_busy;
    rob_idx_t      rs2_tag;

    // Issue stage / ROB side
    modport master (
        output issue, issue_rd, issue_rob_idx, rob_regfile_bus, flush, rs1_idx, rs2_idx,
        input  rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag
    );

    // Register file side
    modport slave (
        input  issue, issue_rd, issue_rob_idx, rob_regfile_bus, flush, rs1_idx, rs2_idx,
        output rs1_value, rs1_busy, rs1_tag, rs2_value, rs2_busy, rs2_tag
    );
endinterface

// File: rtl/regfile_rat_read_port.sv
// rtl/regfile_rat_read_port.sv - combinational operand read with same-cycle commit forwarding
module regfile_rat_read_port
    import rv_structs::*;
    import rob_entry_structs::*;
    import regfile_rat_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_REGS
) (
    input  reg_idx_t                               idx,
    input  logic [NUM_ENTRIES-1:0][XLEN-1:0]       values,
    input  logic [NUM_ENTRIES-1:0]                 busy_bits,
    input  logic [NUM_ENTRIES-1:0][ROB_IDX_W-1:0]  tags,
    input  rob_to_regfile                          commit,
    output xlen_t                                  value,
    output logic                                   busy,
    output rob_idx_t                               tag
);
    logic fwd;

    // x0 reads as all-zero; a commit retiring the pending writer is visible in the same cycle
    always_comb begin
        fwd   = 1'b0;
        value = '0;
        busy  = 1'b0;
        tag   = '0;
        if (idx != '0) begin
            fwd = commit.valid && (commit.regfile_idx == idx) &&
                  busy_bits[idx] && (tags[idx] == commit.rob_idx);
            if (fwd) begin
                value = commit.value;
                busy  = 1'b0;
                tag   = commit.rob_idx;
            end else begin
                value = values[idx];
                busy  = busy_bits[idx];
                tag   = tags[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_rat.sv
// rtl/regfile_rat.sv - architectural register file with per-register rename tags
module regfile_rat
    import rv_structs::*;
    import rob_entry_structs::*;
    import regfile_rat_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_REGS
) (
    input  logic          clk,
    input  logic          rst,
    regfile_rat_if.slave  bus
);
    logic [NUM_ENTRIES-1:0][XLEN-1:0]      value_q;
    logic [NUM_ENTRIES-1:0]                busy_q;
    logic [NUM_ENTRIES-1:0][ROB_IDX_W-1:0] tag_q;

    rob_to_regfile commit;
    logic          issue_we;
    logic          commit_we;
    logic          commit_clr;

    assign commit    = bus.rob_regfile_bus;
    assign issue_we  = bus.issue && (bus.issue_rd != '0);
    assign commit_we = commit.valid && (commit.regfile_idx != '0);

    // Only the writer the RAT is waiting for may release the register, and never while it is being renamed again
    assign commit_clr = commit_we &&
                        busy_q[commit.regfile_idx] &&
                        (tag_q[commit.regfile_idx] == commit.rob_idx) &&
                        !(issue_we && (bus.issue_rd == commit.regfile_idx));

    // Architectural values always take commits; rename state follows issue, commit release and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            if (commit_we) begin
                value_q[commit.regfile_idx] <= commit.value;
            end
            if (bus.flush) begin
                busy_q <= '0;
            end else begin
                if (commit_clr) begin
                    busy_q[commit.regfile_idx] <= 1'b0;
                end
                if (issue_we) begin
                    busy_q[bus.issue_rd] <= 1'b1;
                    tag_q[bus.issue_rd]  <= bus.issue_rob_idx;
                end
            end
        end
    end

    regfile_rat_read_port #(.NUM_ENTRIES(NUM_ENTRIES)) u_rd1 (
        .idx       (bus.rs1_idx),
        .values    (value_q),
        .busy_bits (busy_q),
        .tags      (tag_q),
        .commit    (commit),
        .value     (bus.rs1_value),
        .busy      (bus.rs1_busy),
        .tag       (bus.rs1_tag)
    );

    regfile_rat_read_port #(.NUM_ENTRIES(NUM_ENTRIES)) u_rd2 (
        .idx       (bus.rs2_idx),
        .values    (value_q),
        .busy_bits (busy_q),
        .tags      (tag_q),
        .commit    (commit),
        .value     (bus.rs2_value),
        .busy      (bus.rs2_busy),
        .tag       (bus.rs2_tag)
    );
endmodule

// File: tb/tb_regfile_rat.sv
// tb/tb_regfile_rat.sv - directed vector bench for regfile_rat
module tb_regfile_rat;
    logic clk;
    logic rst;

    regfile_rat_if bus ();

    regfile_rat dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        chk;
        logic        issue;
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic        cv;
        logic [31:0] cval;
        logic [4:0]  crob;
        logic [4:0]  creg;
        logic        flush;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1v;
        logic        e1b;
        logic [4:0]  e1t;
        logic [31:0] e2v;
        logic        e2b;
        logic [4:0]  e2t;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d", name, act, act, exp);
        end
    endtask

    task automatic check_rs1(input string name, input logic [31:0] v, input logic b, input logic [4:0] t);
        check({name, ".rs1_value"}, bus.rs1_value, v);
        check({name, ".rs1_busy"}, {31'd0, bus.rs1_busy}, {31'd0, b});
        check({name, ".rs1_tag"}, {27'd0, bus.rs1_tag}, {27'd0, t});
    endtask

    task automatic check_rs2(input string name, input logic [31:0] v, input logic b, input logic [4:0] t);
        check({name, ".rs2_value"}, bus.rs2_value, v);
        check({name, ".rs2_busy"}, {31'd0, bus.rs2_busy}, {31'd0, b});
        check({name, ".rs2_tag"}, {27'd0, bus.rs2_tag}, {27'd0, t});
    endtask

    task automatic drive(input logic r, input logic iss, input logic [4:0] rd, input logic [4:0] rob,
                         input logic cv, input logic [31:0] cval, input logic [4:0] crob,
                         input logic [4:0] creg, input logic fl, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        rst                             = r;
        bus.issue                       = iss;
        bus.issue_rd                    = rd;
        bus.issue_rob_idx               = rob;
        bus.rob_regfile_bus.valid       = cv;
        bus.rob_regfile_bus.value       = cval;
        bus.rob_regfile_bus.rob_idx     = crob;
        bus.rob_regfile_bus.regfile_idx = creg;
        bus.flush                       = fl;
        bus.rs1_idx                     = rs1;
        bus.rs2_idx                     = rs2;
    endtask

    initial begin
        //           rst chk iss rd rob cv cval crob creg fl rs1 rs2  e1v e1b e1t  e2v e2b e2t
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0,   0, 0,  0,   0, 0};
        vecs[1]  = '{0, 1, 1, 0, 7, 0, 0,   0, 0, 0, 5, 0,   0,   0, 0,  0,   0, 0};
        vecs[2]  = '{0, 1, 1, 3, 4, 0, 0,   0, 0, 0, 0, 0,   0,   0, 0,  0,   0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3, 0,   0,   1, 4,  0,   0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 1, 156, 4, 3, 0, 3, 5,   156, 0, 4,  0,   0, 0};
        vecs[5]  = '{0, 1, 1, 3, 4, 0, 0,   0, 0, 0, 3, 0,   156, 0, 4,  0,   0, 0};
        vecs[6]  = '{0, 1, 1, 3, 9, 0, 0,   0, 0, 0, 3, 0,   156, 1, 4,  0,   0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 1, 200, 4, 3, 0, 3, 0,   156, 1, 9,  0,   0, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 1, 209, 9, 3, 0, 3, 3,   209, 0, 9,  209, 0, 9};
        vecs[9]  = '{0, 1, 1, 6, 2, 0, 0,   0, 0, 0, 3, 6,   209, 0, 9,  0,   0, 0};
        vecs[10] = '{0, 1, 1, 6, 2, 1, 206, 2, 6, 0, 6, 3,   206, 0, 2,  209, 0, 9};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 6, 0,   206, 1, 2,  0,   0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].issue, vecs[i].rd, vecs[i].rob, vecs[i].cv, vecs[i].cval,
                  vecs[i].crob, vecs[i].creg, vecs[i].flush, vecs[i].rs1, vecs[i].rs2);
            #2;
            if (vecs[i].chk) begin
                check_rs1($sformatf("vec%0d", i), vecs[i].e1v, vecs[i].e1b, vecs[i].e1t);
                check_rs2($sformatf("vec%0d", i), vecs[i].e2v, vecs[i].e2b, vecs[i].e2t);
            end
        end

        // Rename every register, then flush alongside an issue and a commit
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            drive(0, 1, r[4:0], r[4:0], 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 31);
        #2;
        check_rs1("renamed_x10", 0, 1, 10);
        check_rs2("renamed_x31", 0, 1, 31);
        @(negedge clk);
        drive(0, 1, 10, 0, 1, 231, 31, 31, 1, 3, 31);
        #2;
        check_rs2("flush_fwd_x31", 231, 0, 31);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 31);
        #2;
        check_rs1("flush_x10", 0, 0, 10);
        check_rs2("flush_x31", 231, 0, 31);
        for (int r = 1; r < 32; r++) begin
            bus.rs1_idx = r[4:0];
            #1;
            check($sformatf("flush_busy_x%0d", r), {31'd0, bus.rs1_busy}, 32'd0);
        end
        bus.rs1_idx = 5'd3;
        bus.rs2_idx = 5'd6;
        #1;
        check("flush_keep_x3", bus.rs1_value, 32'd209);
        check("flush_keep_x6", bus.rs2_value, 32'd206);

        // Reset in the middle of activity overrides a same-cycle commit
        @(negedge clk);
        drive(0, 1, 8, 8, 0, 0, 0, 0, 0, 8, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 3);
        #2;
        check_rs1("pre_rst_x8", 0, 1, 8);
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 208, 8, 8, 0, 8, 3);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 3);
        #2;
        check_rs1("post_rst_x8", 0, 0, 0);
        check_rs2("post_rst_x3", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
